// File: rtl/wb_local_bridge.sv
// wb_local_bridge: Wishbone slave bridged onto a memory-controller local port.
// Writes are posted and reads are limited to one outstanding. Both go through
// an in-order request queue that the issue FSM drains onto the command port.
// Optional one-line read cache is enabled by defining WB_LOCAL_BRIDGE_RDCACHE_EN.
module wb_local_bridge #(
  parameter int WB_DW      = 64,
  parameter int LOCAL_DW   = 256,
  parameter int LOCAL_AW   = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [63:0]           wb_adr_i,
  input  logic [WB_DW-1:0]      wb_dat_i,
  output logic [WB_DW-1:0]      wb_dat_o,
  input  logic [WB_DW/8-1:0]    wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic                  local_init_done,
  input  logic                  local_ready,
  output logic [LOCAL_AW-1:0]   local_address,
  output logic                  local_burstbegin,
  output logic                  local_read_req,
  output logic                  local_write_req,
  output logic [LOCAL_DW-1:0]   local_wdata,
  output logic [LOCAL_DW/8-1:0] local_be,
  output logic [2:0]            local_size,
  input  logic                  local_rdata_valid,
  input  logic [LOCAL_DW-1:0]   local_rdata
);
  localparam int R         = LOCAL_DW / WB_DW;
  localparam int SEL_W     = WB_DW / 8;
  localparam int BE_W      = LOCAL_DW / 8;
  localparam int BYTE_LOG  = $clog2(SEL_W);
  localparam int LINE_OFF  = $clog2(BE_W);
  localparam int LANE_BITS = LINE_OFF - BYTE_LOG;
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int TOP       = LINE_OFF + LOCAL_AW;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE, S_WAIT_RD} state_t;

  state_t              r_state;
  logic                r_ack, r_err, r_rty, r_rd_pend;
  logic [WB_DW-1:0]    r_dat;
  logic [LANE_W-1:0]   r_rd_lane;

  logic                r_q_we   [FIFO_DEPTH];
  logic [LOCAL_AW-1:0] r_q_line [FIFO_DEPTH];
  logic [LANE_W-1:0]   r_q_lane [FIFO_DEPTH];
  logic [WB_DW-1:0]    r_q_data [FIFO_DEPTH];
  logic [SEL_W-1:0]    r_q_sel  [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic [LANE_W-1:0]   w_lane;
  logic [LOCAL_AW-1:0] w_line;
  logic                w_oor, w_req, w_full, w_empty, w_push, w_issue, w_rd_done;
  logic                w_take_rty, w_take_err, w_take_wr, w_take_rd, w_take_hit;
  logic                w_hit;
  logic [WB_DW-1:0]    w_hit_data;
  logic [BYTE_LOG-1:0] w_unused_adr;

  // Address decode: byte offset | lane | line | must-be-zero
  generate
    if (LANE_BITS > 0) begin : g_lane
      assign w_lane = wb_adr_i[LINE_OFF-1:BYTE_LOG];
    end else begin : g_nolane
      assign w_lane = '0;
    end
    if (TOP < 64) begin : g_oor
      assign w_oor = |wb_adr_i[63:TOP];
    end else begin : g_nooor
      assign w_oor = 1'b0;
    end
  endgenerate
  assign w_line       = wb_adr_i[TOP-1:LINE_OFF];
  assign w_unused_adr = wb_adr_i[BYTE_LOG-1:0];

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // An outstanding read counts as a pending response, so it blocks new requests.
  assign w_req     = wb_cyc_i && wb_stb_i && !(r_ack || r_err || r_rty || r_rd_pend);
  // The strobe is qualified by local_ready in the same cycle so a command is
  // presented only when the controller takes it, and the head pops on that edge.
  assign w_issue   = (r_state == S_IDLE) && !w_empty && local_ready;
  assign w_rd_done = (r_state == S_WAIT_RD) && local_rdata_valid;
  assign w_push    = w_take_wr || w_take_rd;

  // Request acceptance priority: retry, error, then write or read
  always_comb begin
    w_take_rty = 1'b0;
    w_take_err = 1'b0;
    w_take_wr  = 1'b0;
    w_take_rd  = 1'b0;
    w_take_hit = 1'b0;
    if (w_req) begin
      if (!local_init_done)  w_take_rty = 1'b1;
      else if (w_oor)        w_take_err = 1'b1;
      else if (wb_we_i)      w_take_wr  = !w_full;
      else if (w_hit)        w_take_hit = 1'b1;
      else                   w_take_rd  = !w_full;
    end
  end

`ifdef WB_LOCAL_BRIDGE_RDCACHE_EN
  logic                r_c_valid;
  logic [LOCAL_AW-1:0] r_c_tag, r_rd_line;
  logic [LOCAL_DW-1:0] r_c_data;

  // A hit is only served when the queue is empty, so no queued write can be bypassed.
  assign w_hit      = r_c_valid && (r_c_tag == w_line) && w_empty;
  assign w_hit_data = r_c_data[w_lane*WB_DW +: WB_DW];

  // Cache fill on read completion; merge of accepted writes to the cached line
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_c_valid <= 1'b0;
      r_c_tag   <= '0;
      r_c_data  <= '0;
      r_rd_line <= '0;
    end else begin
      if (w_take_rd) r_rd_line <= w_line;
      if (w_rd_done) begin
        r_c_valid <= 1'b1;
        r_c_tag   <= r_rd_line;
        r_c_data  <= local_rdata;
      end else if (w_take_wr && r_c_valid && (r_c_tag == w_line)) begin
        for (int b = 0; b < SEL_W; b++)
          if (wb_sel_i[b]) r_c_data[w_lane*WB_DW + b*8 +: 8] <= wb_dat_i[b*8 +: 8];
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  // Registered one-cycle Wishbone responses, read data and outstanding-read tracking
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rty     <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_lane <= '0;
      r_dat     <= '0;
    end else begin
      r_ack <= w_take_wr || w_take_hit || w_rd_done;
      r_err <= w_take_err;
      r_rty <= w_take_rty;
      if (w_take_rd) begin
        r_rd_pend <= 1'b1;
        r_rd_lane <= w_lane;
      end else if (w_rd_done) begin
        r_rd_pend <= 1'b0;
      end
      if (w_rd_done)       r_dat <= local_rdata[r_rd_lane*WB_DW +: WB_DW];
      else if (w_take_hit) r_dat <= w_hit_data;
    end
  end

  // Request queue payload storage
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_q_we[r_wr_ptr]   <= wb_we_i;
      r_q_line[r_wr_ptr] <= w_line;
      r_q_lane[r_wr_ptr] <= w_lane;
      r_q_data[r_wr_ptr] <= wb_dat_i;
      r_q_sel[r_wr_ptr]  <= wb_sel_i;
    end
  end

  // Request queue pointers and occupancy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: a popped read parks in WAIT_RD until its line returns
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_issue && !r_q_we[r_rd_ptr]) r_state <= S_WAIT_RD;
        S_WAIT_RD: if (local_rdata_valid) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign local_burstbegin = w_issue;
  assign local_read_req   = w_issue && !r_q_we[r_rd_ptr];
  assign local_write_req  = w_issue && r_q_we[r_rd_ptr];
  assign local_address    = r_q_line[r_rd_ptr];
  assign local_wdata      = {R{r_q_data[r_rd_ptr]}};
  assign local_be         = BE_W'(r_q_sel[r_rd_ptr]) << (r_q_lane[r_rd_ptr] * SEL_W);
  assign local_size       = 3'b001;

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = r_rty;
  assign wb_dat_o = r_dat;
endmodule

// File: tb/tb_wb_local_bridge.sv
// Directed bench for wb_local_bridge with command and response scoreboards.
module tb_wb_local_bridge;
  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic [63:0]   wb_adr_i = '0;
  logic [63:0]   wb_dat_i = '0;
  logic [63:0]   wb_dat_o;
  logic [7:0]    wb_sel_i = '0;
  logic          wb_we_i  = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_ack_o, wb_err_o, wb_rty_o;
  logic          local_init_done = 1'b0;
  logic          local_ready = 1'b1;
  logic [23:0]   local_address;
  logic          local_burstbegin, local_read_req, local_write_req;
  logic [255:0]  local_wdata;
  logic [31:0]   local_be;
  logic [2:0]    local_size;
  logic          local_rdata_valid = 1'b0;
  logic [255:0]  local_rdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           we;
    logic [23:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  be;
  } cmd_t;
  typedef struct {
    int          rsp;
    logic [63:0] rd;
    int          lat;
  } rsp_t;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  wb_local_bridge dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .local_init_done(local_init_done), .local_ready(local_ready),
    .local_address(local_address), .local_burstbegin(local_burstbegin),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_wdata(local_wdata), .local_be(local_be), .local_size(local_size),
    .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [23:0] line, input logic [63:0] d, input logic [31:0] be);
    exp_cmd.push_back('{1'b1, line, {4{d}}, be});
  endtask

  task automatic push_rd(input logic [23:0] line);
    exp_cmd.push_back('{1'b0, line, 256'h0, 32'h0});
  endtask

  // Command monitor: every strobe must match the head of the expected-command queue
  always @(negedge wb_clk_i) begin
    if (local_burstbegin) begin
      cmd_t c;
      check("cmd_ready", local_ready, 1'b1);
      check("cmd_size", local_size, 3'b001);
      check("cmd_expected", exp_cmd.size() != 0, 1'b1);
      if (exp_cmd.size() != 0) begin
        c = exp_cmd.pop_front();
        check("cmd_kind", {local_read_req, local_write_req}, c.we ? 2'b01 : 2'b10);
        check("cmd_addr", local_address, c.addr);
        if (c.we) begin
          check("cmd_wdata", local_wdata, c.wdata);
          check("cmd_be", local_be, c.be);
        end
      end
    end
  end

  // Wishbone master transfer with response scoreboard (rsp: ack=1 err=2 rty=4)
  task automatic do_xfer(input bit we_b, input logic [63:0] adr, input logic [63:0] dat,
                         input logic [7:0] sel, input int e_rsp, input logic [63:0] e_rd,
                         input int e_lat);
    rsp_t e;
    int rsp = 0;
    int lat = 0;
    logic [63:0] rd = '0;
    exp_rsp.push_back('{e_rsp, e_rd, e_lat});
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we_b;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int i = 0; i < 100 && rsp == 0; i++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o || wb_err_o || wb_rty_o) begin
        rsp = (wb_ack_o ? 1 : 0) + (wb_err_o ? 2 : 0) + (wb_rty_o ? 4 : 0);
        rd  = wb_dat_o;
      end else begin
        lat++;
      end
    end
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk_i);
    check("resp_one_cycle", {wb_ack_o, wb_err_o, wb_rty_o}, 3'b000);
    e = exp_rsp.pop_front();
    check("resp_kind", rsp, e.rsp);
    if (e.lat >= 0) check("resp_latency", lat, e.lat);
    if (e.rsp == 1 && !we_b) check("read_data", rd, e.rd);
  endtask

  // Controller read model: return a line some cycles after the read command
  task automatic ctrl_rsp(input logic [255:0] line, input int dly);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (local_burstbegin && local_read_req) seen = 1'b1;
    end
    check("ctrl_saw_read", seen, 1'b1);
    if (seen) begin
      repeat (dly) @(negedge wb_clk_i);
      local_rdata = line; local_rdata_valid = 1'b1;
      @(negedge wb_clk_i);
      local_rdata_valid = 1'b0;
    end
  endtask

  initial begin
    bit got;
    bit saw_rsp;
    // reset values
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_ack", {wb_ack_o, wb_err_o, wb_rty_o}, 3'b000);
    check("rst_cmd", {local_burstbegin, local_read_req, local_write_req}, 3'b000);
    check("rst_dat", wb_dat_o, 64'h0);
    check("rst_size", local_size, 3'b001);

    // not calibrated: retry, no command
    do_xfer(1'b0, 64'h40, 64'h0, 8'hFF, 4, 64'h0, 1);
    local_init_done = 1'b1;
    // out of range (bit above the line field): error, no command
    do_xfer(1'b0, 64'h2000_0000, 64'h0, 8'hFF, 2, 64'h0, 1);

    // posted writes, lane 0 / lane 3 / top of line range
    push_wr(24'h8, 64'h1122334455667788, 32'h0000_00FF);
    do_xfer(1'b1, 64'h100, 64'h1122334455667788, 8'hFF, 1, 64'h0, 1);
    push_wr(24'h8, 64'hCAFE_F00D_0000_1234, 32'h0F00_0000);
    do_xfer(1'b1, 64'h118, 64'hCAFE_F00D_0000_1234, 8'h0F, 1, 64'h0, 1);
    push_wr(24'hFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'hFF00_0000);
    do_xfer(1'b1, 64'h1FFF_FFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'h0, 1);
    repeat (2) @(negedge wb_clk_i);

    // fill the queue with the controller stalled, fifth write waits for a pop
    local_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_wr(24'h80 + 24'(k), 64'hA0 + 64'(k), 32'h0000_00FF);
      do_xfer(1'b1, 64'h1000 + 64'(k * 32), 64'hA0 + 64'(k), 8'hFF, 1, 64'h0, 1);
    end
    push_wr(24'h84, 64'hA4, 32'h0000_00FF);
    fork
      do_xfer(1'b1, 64'h1080, 64'hA4, 8'hFF, 1, 64'h0, 6);
      begin repeat (5) @(posedge wb_clk_i); #1 local_ready = 1'b1; end
    join
    repeat (8) @(negedge wb_clk_i);
    check("drain_after_stall", exp_cmd.size(), 0);

    // write then read of the same line: ordered issue, lane 1 returned
    push_wr(24'h8, 64'h55, 32'h0000_FF00);
    do_xfer(1'b1, 64'h108, 64'h55, 8'hFF, 1, 64'h0, 1);
    push_rd(24'h8);
    fork
      do_xfer(1'b0, 64'h108, 64'h0, 8'hFF, 1, 64'hDEAD, 4);
      ctrl_rsp({64'h4, 64'h3, 64'hDEAD, 64'h1}, 2);
    join
    push_wr(24'h9, 64'h77, 32'h0000_00FF);
    do_xfer(1'b1, 64'h120, 64'h77, 8'hFF, 1, 64'h0, 1);
    check("rdata_held", wb_dat_o, 64'hDEAD);

    // reset while waiting for read data: read abandoned, late data ignored
    push_rd(24'h18);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 64'h300; wb_sel_i = 8'hFF;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge wb_clk_i);
      if (local_burstbegin && local_read_req) got = 1'b1;
    end
    check("rst_rd_issued", got, 1'b1);
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_dat_cleared", wb_dat_o, 64'h0);
    local_rdata = {4{64'hBAD}}; local_rdata_valid = 1'b1;
    @(negedge wb_clk_i);
    local_rdata_valid = 1'b0;
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wb_ack_o || wb_err_o || wb_rty_o) saw_rsp = 1'b1;
    end
    check("abandoned_read_no_ack", saw_rsp, 1'b0);
    push_wr(24'h20, 64'h99, 32'h0000_00FF);
    do_xfer(1'b1, 64'h400, 64'h99, 8'hFF, 1, 64'h0, 1);

    // read line, partial write into it, read it back
    push_rd(24'h10);
    fork
      do_xfer(1'b0, 64'h200, 64'h0, 8'hFF, 1, 64'hC0, 4);
      ctrl_rsp({64'hC3, 64'hC2, 64'h1111_2222_3333_4400, 64'hC0}, 2);
    join
    push_wr(24'h10, 64'hAA, 32'h0000_0100);
    do_xfer(1'b1, 64'h208, 64'hAA, 8'h01, 1, 64'h0, 1);
    repeat (2) @(negedge wb_clk_i);
`ifdef WB_LOCAL_BRIDGE_RDCACHE_EN
    do_xfer(1'b0, 64'h208, 64'h0, 8'hFF, 1, 64'h1111_2222_3333_44AA, 1);
`else
    push_rd(24'h10);
    fork
      do_xfer(1'b0, 64'h208, 64'h0, 8'hFF, 1, 64'h1111_2222_3333_44AA, 4);
      ctrl_rsp({64'hC3, 64'hC2, 64'h1111_2222_3333_44AA, 64'hC0}, 2);
    join
`endif

    repeat (10) @(negedge wb_clk_i);
    check("all_cmds_issued", exp_cmd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
